// File: rtl/pipeline_pkg.sv
//------------------------------------------------------------------------------
// Module   : pipeline_pkg
// Purpose  : Shared FSM state encoding and event-counter width for the pipeline
//            controller.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pipeline_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
//------------------------------------------------------------------------------
// Module   : sat_counter
// Purpose  : Event counter that sticks at all-ones instead of wrapping.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sat_counter
    import pipeline_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
//------------------------------------------------------------------------------
// Module   : pipeline_ctrl
// Purpose  : Fetch-PC sequencing, hazard stall/flush control and halt draining
//            for a 5-stage pipeline, with redirect/stall event counters.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int PC_W      = 9,
    parameter int DRAIN_CYC = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic             load_use,
    input  logic             halt,
    output logic [PC_W-1:0]  pc,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             halted,
    output logic             misalign,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [PC_W-1:0] c_pc_step    = PC_W'(4);
    localparam logic [2:0]      c_drain_load = 3'(DRAIN_CYC - 1);

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [2:0]      r_drain_cnt;
    logic            r_halted;
    logic            r_misalign;

    logic [PC_W-1:0] w_br_pc;
    logic            w_run;
    logic            w_redirect;
    logic            w_stall;

    // Target is word-aligned by dropping its low two bits.
    assign w_br_pc    = {br_target[PC_W-1:2], 2'b00};
    assign w_run      = reset && (r_state == RUN);
    assign w_redirect = w_run && !halt && br_taken;
    assign w_stall    = w_run && !halt && !br_taken && load_use;

    generate
        if (PC_W < 32) begin : g_tgt_unused
            logic w_unused_tgt;
            assign w_unused_tgt = ^br_target[31:PC_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_pc        <= '0;
            r_drain_cnt <= '0;
            r_halted    <= 1'b0;
            r_misalign  <= 1'b0;
        end else begin
            // Lags HALTED by one edge so halted rises DRAIN_CYC+1 edges after halt.
            r_halted <= (r_state == HALTED);
            case (r_state)
                IDLE: begin
                    r_state <= RUN;
                end
                RUN: begin
                    if (halt) begin
                        r_drain_cnt <= c_drain_load;
                        r_state     <= DRAIN;
                    end else if (br_taken) begin
                        r_pc <= w_br_pc;
                        if (br_target[1:0] != 2'b00) begin
                            r_misalign <= 1'b1;
                        end
                    end else if (!load_use) begin
                        r_pc <= r_pc + c_pc_step;
                    end
                end
                DRAIN: begin
                    if (r_drain_cnt == 3'd0) begin
                        r_state <= HALTED;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 3'd1;
                    end
                end
                HALTED: begin
                    r_state <= HALTED;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Everything outside RUN (and reset itself) presents bubble-everything values.
    always_comb begin
        if_id_we    = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (w_run) begin
            if (halt) begin
                if_id_we    = 1'b0;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (br_taken) begin
                if_id_we    = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                if_id_we    = 1'b0;
                if_id_flush = 1'b0;
                id_ex_flush = 1'b1;
            end else begin
                if_id_we    = 1'b1;
                if_id_flush = 1'b0;
                id_ex_flush = 1'b0;
            end
        end
    end

    sat_counter u_redirect_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_redirect),
        .o_count (redirect_cnt)
    );

    sat_counter u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_stall),
        .o_count (stall_cnt)
    );

    assign pc       = r_pc;
    assign halted   = r_halted;
    assign misalign = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_pipeline_ctrl
// Purpose  : Directed self-checking bench for pipeline_ctrl (PC_W=9, DRAIN_CYC=2).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        load_use = 1'b0;
    logic        halt = 1'b0;
    logic [8:0]  pc;
    logic        if_id_we;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        halted;
    logic        misalign;
    logic [15:0] redirect_cnt;
    logic [15:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.PC_W(9), .DRAIN_CYC(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .load_use     (load_use),
        .halt         (halt),
        .pc           (pc),
        .if_id_we     (if_id_we),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .halted       (halted),
        .misalign     (misalign),
        .redirect_cnt (redirect_cnt),
        .stall_cnt    (stall_cnt)
    );

    // Advance one rising edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        br_taken  = 1'b0;
        br_target = '0;
        load_use  = 1'b0;
        halt      = 1'b0;
    endtask

    // Leaves the DUT in its first RUN cycle with pc=0.
    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        step();
        step();
        n_tests++; if (pc !== 9'h000) begin n_fail++; $display("FAIL reset_pc got=%h exp=000", pc); end
        n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got=%b exp=0", halted); end
        n_tests++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got=%b exp=0", misalign); end
        n_tests++; if (redirect_cnt !== 16'h0 || stall_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnts got=%h/%h exp=0/0", redirect_cnt, stall_cnt); end
        n_tests++; if ({if_id_we, if_id_flush, id_ex_flush} !== 3'b011) begin n_fail++; $display("FAIL reset_comb got=%b exp=011", {if_id_we, if_id_flush, id_ex_flush}); end
        reset = 1'b1;
        #1;
        n_tests++; if ({if_id_we, if_id_flush, id_ex_flush} !== 3'b011 || pc !== 9'h000) begin n_fail++; $display("FAIL idle_outputs got=%b pc=%h exp=011 pc=000", {if_id_we, if_id_flush, id_ex_flush}, pc); end
        step();
        n_tests++; if (pc !== 9'h000 || if_id_we !== 1'b1) begin n_fail++; $display("FAIL run_entry got pc=%h we=%b exp pc=000 we=1", pc, if_id_we); end
        for (int i = 1; i <= 3; i++) begin
            step();
            n_tests++; if (pc !== 9'(4 * i)) begin n_fail++; $display("FAIL seq_pc_%0d got=%h exp=%h", i, pc, 9'(4 * i)); end
        end
    endtask

    task automatic test_branch();
        do_reset();
        br_taken  = 1'b1;
        br_target = 32'h0000_0040;
        load_use  = 1'b1;
        #1;
        n_tests++; if ({if_id_flush, id_ex_flush} !== 2'b11) begin n_fail++; $display("FAIL br_flush got=%b exp=11", {if_id_flush, id_ex_flush}); end
        step();
        clear_inputs();
        n_tests++; if (pc !== 9'h040) begin n_fail++; $display("FAIL br_pc got=%h exp=040", pc); end
        n_tests++; if (redirect_cnt !== 16'd1 || stall_cnt !== 16'd0) begin n_fail++; $display("FAIL br_cnts got=%0d/%0d exp=1/0", redirect_cnt, stall_cnt); end
        n_tests++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL br_aligned_misalign got=%b exp=0", misalign); end
        // High target bits beyond the PC width must not matter.
        br_taken  = 1'b1;
        br_target = 32'hFFFF_FE80;
        step();
        clear_inputs();
        n_tests++; if (pc !== 9'h080 || redirect_cnt !== 16'd2) begin n_fail++; $display("FAIL br_highbits got pc=%h cnt=%0d exp pc=080 cnt=2", pc, redirect_cnt); end
    endtask

    task automatic test_load_use();
        do_reset();
        repeat (4) step();
        n_tests++; if (pc !== 9'h010) begin n_fail++; $display("FAIL lu_setup_pc got=%h exp=010", pc); end
        load_use = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if ({if_id_we, if_id_flush, id_ex_flush} !== 3'b001 || pc !== 9'h010) begin n_fail++; $display("FAIL lu_stall_%0d got=%b pc=%h exp=001 pc=010", i, {if_id_we, if_id_flush, id_ex_flush}, pc); end
            step();
        end
        load_use = 1'b0;
        n_tests++; if (pc !== 9'h010 || stall_cnt !== 16'd3) begin n_fail++; $display("FAIL lu_after got pc=%h cnt=%0d exp pc=010 cnt=3", pc, stall_cnt); end
        step();
        n_tests++; if (pc !== 9'h014) begin n_fail++; $display("FAIL lu_resume got=%h exp=014", pc); end
    endtask

    task automatic test_halt();
        do_reset();
        repeat (8) step();
        n_tests++; if (pc !== 9'h020) begin n_fail++; $display("FAIL halt_setup_pc got=%h exp=020", pc); end
        halt      = 1'b1;
        br_taken  = 1'b1;
        br_target = 32'h0000_0100;
        #1;
        n_tests++; if ({if_id_flush, id_ex_flush} !== 2'b11) begin n_fail++; $display("FAIL halt_flush got=%b exp=11", {if_id_flush, id_ex_flush}); end
        step();
        // Edges 1..6 after the halt edge with inputs toggling; halted rises at edge 3.
        for (int e = 1; e <= 6; e++) begin
            halt     = e[0];
            br_taken = ~e[0];
            load_use = 1'b1;
            #1;
            n_tests++; if ({if_id_we, if_id_flush, id_ex_flush} !== 3'b011) begin n_fail++; $display("FAIL drain_comb_%0d got=%b exp=011", e, {if_id_we, if_id_flush, id_ex_flush}); end
            step();
            n_tests++; if (halted !== (e >= 3)) begin n_fail++; $display("FAIL halted_edge_%0d got=%b exp=%b", e, halted, (e >= 3)); end
        end
        clear_inputs();
        n_tests++; if (pc !== 9'h020 || redirect_cnt !== 16'd0 || stall_cnt !== 16'd0) begin n_fail++; $display("FAIL halt_frozen got pc=%h r=%0d s=%0d exp pc=020 r=0 s=0", pc, redirect_cnt, stall_cnt); end
    endtask

    task automatic test_misalign();
        do_reset();
        br_taken  = 1'b1;
        br_target = 32'h0000_0042;
        step();
        clear_inputs();
        n_tests++; if (pc !== 9'h040 || misalign !== 1'b1) begin n_fail++; $display("FAIL mis_set got pc=%h mis=%b exp pc=040 mis=1", pc, misalign); end
        br_taken  = 1'b1;
        br_target = 32'h0000_0080;
        step();
        clear_inputs();
        step();
        n_tests++; if (misalign !== 1'b1 || pc !== 9'h084) begin n_fail++; $display("FAIL mis_sticky got mis=%b pc=%h exp mis=1 pc=084", misalign, pc); end
        halt = 1'b1;
        step();
        clear_inputs();
        repeat (3) step();
        n_tests++; if (halted !== 1'b1 || misalign !== 1'b1) begin n_fail++; $display("FAIL mis_halted got h=%b mis=%b exp h=1 mis=1", halted, misalign); end
        reset = 1'b0;
        step();
        n_tests++; if (pc !== 9'h000 || halted !== 1'b0 || misalign !== 1'b0 || redirect_cnt !== 16'd0) begin n_fail++; $display("FAIL halted_reset got pc=%h h=%b mis=%b r=%0d exp 000/0/0/0", pc, halted, misalign, redirect_cnt); end
        reset = 1'b1;
        #1;
        n_tests++; if (if_id_we !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle got we=%b exp=0", if_id_we); end
        step();
        n_tests++; if (if_id_we !== 1'b1 || pc !== 9'h000) begin n_fail++; $display("FAIL post_reset_run got we=%b pc=%h exp we=1 pc=000", if_id_we, pc); end
    endtask

    task automatic test_saturation();
        do_reset();
        load_use = 1'b1;
        repeat (65537) step();
        load_use = 1'b0;
        n_tests++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL stall_sat got=%h exp=FFFF", stall_cnt); end
        n_tests++; if (pc !== 9'h000) begin n_fail++; $display("FAIL stall_pc got=%h exp=000", pc); end
        br_taken  = 1'b1;
        br_target = 32'h0000_01FC;
        step();
        clear_inputs();
        n_tests++; if (pc !== 9'h1FC) begin n_fail++; $display("FAIL wrap_setup got=%h exp=1FC", pc); end
        step();
        n_tests++; if (pc !== 9'h000 || stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL pc_wrap got pc=%h s=%h exp pc=000 s=FFFF", pc, stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_load_use();
        test_halt();
        test_misalign();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 9, width of the program counter.
REQ-002 SHALL have parameter DRAIN_CYC, default 2, cycles allowed for in-flight instructions (MEM, WB) to retire after halt; legal range 1..7.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset; reset==0 sampled at a rising edge resets the block.
REQ-005 SHALL have port br_taken, input, 1, branch/jal/jalr taken in EX (the branch unit's PcSel).
REQ-006 SHALL have port br_target, input, 32, redirect target from the branch unit (BrPC).
REQ-007 SHALL have port load_use, input, 1, load-use hazard detected in ID.
REQ-008 SHALL have port halt, input, 1, halt instruction present in EX.
REQ-009 SHALL have port pc, output, PC_W, registered fetch address.
REQ-010 SHALL have port if_id_we, output, 1, IF/ID register write enable.
REQ-011 SHALL have port if_id_flush, output, 1, clear IF/ID to bubble.
REQ-012 SHALL have port id_ex_flush, output, 1, clear ID/EX to bubble.
REQ-013 SHALL have port halted, output, 1, registered, core halted.
REQ-014 SHALL have port misalign, output, 1, sticky flag: taken target with br_target[1:0]!=0.
REQ-015 SHALL have ports redirect_cnt and stall_cnt, outputs, 16 each, saturating event counters.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN, HALTED.
REQ-017 IDLE: entered on reset; pc held at 0, if_id_we=0, both flushes=1; unconditional transition to RUN next edge.
REQ-018 RUN, priority halt > br_taken > load_use > normal.
REQ-019 RUN normal: pc <= pc+4 (mod 2^PC_W, wraps silently), if_id_we=1, flushes=0.
REQ-020 RUN br_taken (no halt): pc <= br_target[PC_W-1:2],2'b00; if_id_flush=1, id_ex_flush=1 same cycle (combinational); redirect_cnt increments; load_use ignored that cycle and stall_cnt does not increment.
REQ-021 RUN load_use (no halt, no br_taken): pc held, if_id_we=0, id_ex_flush=1, if_id_flush=0; stall_cnt increments; repeats each cycle load_use stays high.
REQ-022 RUN halt: pc held, if_id_flush=1, id_ex_flush=1, br_taken ignored, drain counter loaded with DRAIN_CYC-1; next state DRAIN.
REQ-023 DRAIN: pc held, if_id_we=0, both flushes=1; counter decrements each cycle; on counter==0 next state HALTED; inputs ignored.
REQ-024 HALTED: halted=1, pc held, if_id_we=0, both flushes=1; remains until reset; inputs ignored.
REQ-025 halted SHALL assert exactly DRAIN_CYC+1 edges after the edge where halt was sampled in RUN.
REQ-026 misalign SHALL set on the edge where a taken redirect with br_target[1:0]!=0 is accepted; cleared only by reset.
REQ-027 Counters SHALL saturate at 16'hFFFF, never wrap.
REQ-028 br_target bits above PC_W-1 SHALL be ignored.

Reset
REQ-029 On reset==0 at an edge: state=IDLE, pc=0, halted=0, misalign=0, redirect_cnt=0, stall_cnt=0, drain counter=0; overrides all inputs, including mid-DRAIN and HALTED.
REQ-030 While reset==0, combinational outputs SHALL equal IDLE values (if_id_we=0, flushes=1).

Structure
REQ-031 State enum (IDLE, RUN, DRAIN, HALTED) and counter width constant SHALL live in a shared package pipeline_pkg.
REQ-032 One sub-module, sat_counter (16-bit, increment enable, synchronous active-low reset), SHALL be instantiated twice; FSM and PC register stay in pipeline_ctrl.

Verification
REQ-033 Reset release, no events: pc 0 during IDLE, then 4, 8, 12 on successive edges; if_id_we=1 from RUN.
REQ-034 br_taken=1, br_target=0x40 in RUN, load_use=1 same cycle: both flushes=1 that cycle, next pc=0x40, redirect_cnt=1, stall_cnt=0.
REQ-035 load_use high 3 cycles at pc=0x10: pc stays 0x10, if_id_we=0, id_ex_flush=1 for 3 cycles, stall_cnt=3, then pc=0x14.
REQ-036 halt and br_taken both 1 with pc=0x20, DRAIN_CYC=2: pc stays 0x20, redirect_cnt unchanged, halted=1 exactly 3 edges later, stays 1 with toggling inputs.
REQ-037 br_taken with br_target=0x42: next pc=0x40, misalign=1 and remains 1 until reset; reset==0 during HALTED returns state to IDLE, pc=0, halted=0 on that edge.
REQ-038 Force 65537 stall cycles: stall_cnt holds 0xFFFF; pc=0x1FC with no events wraps to 0x000 (PC_W=9).
